// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with rename tags.
// Each register carries a value, a busy flag and the ROB id of its pending
// producer. Issue renames a destination to the issuing ROB entry, commit
// writes the retired value and releases the tag only when the committing
// entry is still the register's newest producer. Two combinational source
// lookups return either the value or the producing ROB id, and a matching
// commit is forwarded into them in the same cycle.
module reg_file_rename #(
    parameter int REG_NUM       = 32,
    parameter int ROB_INDEX_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     issue_req,
    input  logic [4:0]               issue_rd,
    input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    input  logic                     commit_valid,
    input  logic [4:0]               commit_rd,
    input  logic [31:0]              commit_val,
    input  logic [ROB_INDEX_BIT-1:0] commit_rob_id,
    input  logic [4:0]               rs1_idx,
    input  logic [4:0]               rs2_idx,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [ROB_INDEX_BIT-1:0] rs1_tag,
    output logic [ROB_INDEX_BIT-1:0] rs2_tag
);

    // Flattened read views of the per-register state; entry 0 is x0.
    logic [REG_NUM-1:0][31:0]              val_all_s;
    logic [REG_NUM-1:0]                    busy_all_s;
    logic [REG_NUM-1:0][ROB_INDEX_BIT-1:0] tag_all_s;

    logic fwd1_s;
    logic fwd2_s;

    // x0 has no storage: it always reads as zero and never becomes busy.
    assign val_all_s[0]  = 32'd0;
    assign busy_all_s[0] = 1'b0;
    assign tag_all_s[0]  = {ROB_INDEX_BIT{1'b0}};

    for (genvar g = 1; g < REG_NUM; g++) begin : g_reg
        logic [31:0]              val_r;
        logic                     busy_r;
        logic [ROB_INDEX_BIT-1:0] tag_r;
        logic                     commit_hit_s;
        logic                     issue_hit_s;
        logic                     release_s;

        assign commit_hit_s = commit_valid && (commit_rd == 5'(g));
        assign issue_hit_s  = issue_req && (issue_rd == 5'(g));
        // Only the newest producer may clear busy; an older retiring entry
        // writes the value but leaves the younger rename in place.
        assign release_s    = commit_hit_s && busy_r && (tag_r == commit_rob_id);

        // Per-register state update: reset, then freeze, then clear/issue/commit.
        always_ff @(posedge clk_in) begin
            if (!rst_n_in) begin
                val_r  <= 32'd0;
                busy_r <= 1'b0;
                tag_r  <= {ROB_INDEX_BIT{1'b0}};
            end else if (rdy_in) begin
                if (commit_hit_s) begin
                    val_r <= commit_val;
                end
                // Flush drops the same-cycle issue; issue beats the release.
                if (clear_in) begin
                    busy_r <= 1'b0;
                    tag_r  <= {ROB_INDEX_BIT{1'b0}};
                end else if (issue_hit_s) begin
                    busy_r <= 1'b1;
                    tag_r  <= issue_rob_id;
                end else if (release_s) begin
                    busy_r <= 1'b0;
                end
            end
        end

        assign val_all_s[g]  = val_r;
        assign busy_all_s[g] = busy_r;
        assign tag_all_s[g]  = tag_r;
    end

    // Source port 1 lookup with same-cycle forwarding of a releasing commit.
    always_comb begin
        fwd1_s  = commit_valid && (commit_rd == rs1_idx) && (rs1_idx != 5'd0)
                  && busy_all_s[rs1_idx] && (tag_all_s[rs1_idx] == commit_rob_id);
        rs1_tag = tag_all_s[rs1_idx];
        if (fwd1_s) begin
            rs1_busy = 1'b0;
            rs1_val  = commit_val;
        end else begin
            rs1_busy = busy_all_s[rs1_idx];
            rs1_val  = val_all_s[rs1_idx];
        end
    end

    // Source port 2 lookup with same-cycle forwarding of a releasing commit.
    always_comb begin
        fwd2_s  = commit_valid && (commit_rd == rs2_idx) && (rs2_idx != 5'd0)
                  && busy_all_s[rs2_idx] && (tag_all_s[rs2_idx] == commit_rob_id);
        rs2_tag = tag_all_s[rs2_idx];
        if (fwd2_s) begin
            rs2_busy = 1'b0;
            rs2_val  = commit_val;
        end else begin
            rs2_busy = busy_all_s[rs2_idx];
            rs2_val  = val_all_s[rs2_idx];
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// Testbench for reg_file_rename: directed stimulus pushes hand-computed
// lookup expectations into a queue; a monitor pops and compares them on the
// falling edge of every cycle flagged as carrying a lookup.
module tb_reg_file_rename;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clear_in;
    logic        issue_req;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_id;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_tag;
    logic [3:0]  rs2_tag;

    typedef struct {
        string       name;
        logic [31:0] v1;
        logic        b1;
        logic [3:0]  t1;
        logic [31:0] v2;
        logic        b2;
        logic [3:0]  t2;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid;
    int   checks;
    int   failures;

    reg_file_rename #(.REG_NUM(32), .ROB_INDEX_BIT(4)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rdy_in       (rdy_in),
        .clear_in     (clear_in),
        .issue_req    (issue_req),
        .issue_rd     (issue_rd),
        .issue_rob_id (issue_rob_id),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .commit_rob_id(commit_rob_id),
        .rs1_idx      (rs1_idx),
        .rs2_idx      (rs2_idx),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Monitor: pop one expectation per flagged cycle and compare both ports.
    always @(negedge clk_in) begin
        exp_t e;
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL monitor_underflow: lookup presented with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (rs1_val !== e.v1 || rs1_busy !== e.b1 || rs1_tag !== e.t1) begin
                    failures++;
                    $display("FAIL %s.rs1: got val=%h busy=%0b tag=%0d, expected val=%h busy=%0b tag=%0d",
                             e.name, rs1_val, rs1_busy, rs1_tag, e.v1, e.b1, e.t1);
                end
                checks++;
                if (rs2_val !== e.v2 || rs2_busy !== e.b2 || rs2_tag !== e.t2) begin
                    failures++;
                    $display("FAIL %s.rs2: got val=%h busy=%0b tag=%0d, expected val=%h busy=%0b tag=%0d",
                             e.name, rs2_val, rs2_busy, rs2_tag, e.v2, e.b2, e.t2);
                end
            end
        end
    end

    // Advance one cycle and return all request inputs to idle.
    task automatic tick();
        @(posedge clk_in);
        #1;
        chk_valid    = 1'b0;
        clear_in     = 1'b0;
        issue_req    = 1'b0;
        issue_rd     = 5'd0;
        issue_rob_id = 4'd0;
        commit_valid = 1'b0;
        commit_rd    = 5'd0;
        commit_val   = 32'd0;
        commit_rob_id = 4'd0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] id);
        issue_req    = 1'b1;
        issue_rd     = rd;
        issue_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] id);
        commit_valid  = 1'b1;
        commit_rd     = rd;
        commit_val    = v;
        commit_rob_id = id;
    endtask

    // Drive both lookup indices this cycle and queue the expected results.
    task automatic look(input string name,
                        input logic [4:0] i1, input logic [31:0] v1, input logic b1, input logic [3:0] t1,
                        input logic [4:0] i2, input logic [31:0] v2, input logic b2, input logic [3:0] t2);
        exp_t e;
        e.name = name;
        e.v1 = v1; e.b1 = b1; e.t1 = t1;
        e.v2 = v2; e.b2 = b2; e.t2 = t2;
        rs1_idx   = i1;
        rs2_idx   = i2;
        exp_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        chk_valid = 1'b0;
        rst_n_in  = 1'b0;
        rdy_in    = 1'b1;
        rs1_idx   = 5'd0;
        rs2_idx   = 5'd0;
        tick();
        tick();
        rst_n_in = 1'b1;

        // 1. Reset state and x0 immunity.
        look("reset_x5_x0", 5'd5, 32'd0, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 4'd0);
        tick();
        issue(5'd0, 4'd3);
        tick();
        look("x0_after_issue", 5'd0, 32'd0, 1'b0, 4'd0, 5'd5, 32'd0, 1'b0, 4'd0);
        tick();

        // 2. Rename, forwarded commit, retired state (tag is left as-is).
        issue(5'd5, 4'd2);
        tick();
        look("x5_renamed", 5'd5, 32'd0, 1'b1, 4'd2, 5'd0, 32'd0, 1'b0, 4'd0);
        tick();
        commit(5'd5, 32'hDEADBEEF, 4'd2);
        look("x5_forward", 5'd0, 32'd0, 1'b0, 4'd0, 5'd5, 32'hDEADBEEF, 1'b0, 4'd2);
        tick();
        look("x5_retired", 5'd5, 32'hDEADBEEF, 1'b0, 4'd2, 5'd0, 32'd0, 1'b0, 4'd0);
        tick();

        // 3. Stale commit writes value, younger rename keeps ownership.
        issue(5'd7, 4'd1);
        tick();
        issue(5'd7, 4'd4);
        tick();
        commit(5'd7, 32'd11, 4'd1);
        look("x7_stale_nofwd", 5'd7, 32'd0, 1'b1, 4'd4, 5'd5, 32'hDEADBEEF, 1'b0, 4'd2);
        tick();
        look("x7_after_stale", 5'd7, 32'd11, 1'b1, 4'd4, 5'd0, 32'd0, 1'b0, 4'd0);
        tick();

        // 4. Same-cycle issue and matching commit: lookup sees pre-issue state.
        issue(5'd9, 4'd5);
        tick();
        issue(5'd9, 4'd6);
        commit(5'd9, 32'd42, 4'd5);
        look("x9_issue_commit_fwd", 5'd9, 32'd42, 1'b0, 4'd5, 5'd7, 32'd11, 1'b1, 4'd4);
        tick();
        look("x9_issue_wins", 5'd9, 32'd42, 1'b1, 4'd6, 5'd0, 32'd0, 1'b0, 4'd0);
        tick();

        // 5. Flush: drops same-cycle issue, still writes committed value.
        issue(5'd1, 4'd1);
        tick();
        issue(5'd2, 4'd2);
        tick();
        issue(5'd3, 4'd3);
        tick();
        clear_in = 1'b1;
        issue(5'd4, 4'd7);
        commit(5'd2, 32'h22, 4'd9);
        look("pre_clear", 5'd1, 32'd0, 1'b1, 4'd1, 5'd4, 32'd0, 1'b0, 4'd0);
        tick();
        look("clear_x1_x2", 5'd1, 32'd0, 1'b0, 4'd0, 5'd2, 32'h22, 1'b0, 4'd0);
        tick();
        look("clear_x3_x4", 5'd3, 32'd0, 1'b0, 4'd0, 5'd4, 32'd0, 1'b0, 4'd0);
        tick();
        look("clear_vals_kept", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0, 5'd7, 32'd11, 1'b0, 4'd0);
        tick();

        // 6. Freeze, forwarding while frozen, then reset with pending renames.
        issue(5'd12, 4'd3);
        tick();
        rdy_in = 1'b0;
        issue(5'd10, 4'd3);
        commit(5'd11, 32'd9, 4'd0);
        tick();
        look("frozen_no_change", 5'd10, 32'd0, 1'b0, 4'd0, 5'd11, 32'd0, 1'b0, 4'd0);
        commit(5'd12, 32'h77, 4'd3);
        tick();
        rdy_in = 1'b1;
        look("x12_after_freeze", 5'd12, 32'd0, 1'b1, 4'd3, 5'd9, 32'd42, 1'b0, 4'd0);
        tick();
        rdy_in = 1'b0;
        commit(5'd12, 32'h77, 4'd3);
        look("fwd_while_frozen", 5'd12, 32'h77, 1'b0, 4'd3, 5'd0, 32'd0, 1'b0, 4'd0);
        tick();
        rdy_in = 1'b1;
        issue(5'd13, 4'd5);
        tick();
        rst_n_in = 1'b0;
        issue(5'd14, 4'd6);
        tick();
        rst_n_in = 1'b1;
        look("reset_x12_x13", 5'd12, 32'd0, 1'b0, 4'd0, 5'd13, 32'd0, 1'b0, 4'd0);
        tick();
        look("reset_x9_x5", 5'd9, 32'd0, 1'b0, 4'd0, 5'd5, 32'd0, 1'b0, 4'd0);
        tick();
        look("reset_x14_x7", 5'd14, 32'd0, 1'b0, 4'd0, 5'd7, 32'd0, 1'b0, 4'd0);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
